// File: rtl/time_set_ctrl.sv
// time_set_ctrl: two-button set-mode sequencer for the clock/calendar datapath.
// ModeBtn walks through the settable fields and back to RUN. AdvBtn sends one-cycle
// advance strobes to the selected field and auto-repeats while it is held. The block
// drops back to RUN after a run of idle cycles in a set state.
//
// state   | meaning
// --------+------------------------------------------------------
// S_RUN   | normal timekeeping, no strobes, Timeset low
// S_MIN   | setting minutes, AdvBtn drives Minadv
// S_HRS   | setting hours, AdvBtn drives Hrsadv
// S_DAY   | setting day-of-week, AdvBtn drives Dayadv
// S_DATE  | setting date, AdvBtn drives DateAdv
// S_MONTH | setting month, AdvBtn drives MonthAdv
// 6, 7    | unreachable, fall back to S_RUN on the next edge

module time_set_ctrl #(
  parameter int unsigned HOLD_DLY = 8,
  parameter int unsigned RPT_PER  = 2,
  parameter int unsigned IDLE_TO  = 64,
  parameter int unsigned CW       = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ModeBtn,
  input  logic       AdvBtn,
  output logic       Timeset,
  output logic       Minadv,
  output logic       Hrsadv,
  output logic       Dayadv,
  output logic       DateAdv,
  output logic       MonthAdv,
  output logic [2:0] Field
);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_MIN   = 3'd1,
    S_HRS   = 3'd2,
    S_DAY   = 3'd3,
    S_DATE  = 3'd4,
    S_MONTH = 3'd5
  } state_t;

  localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_DLY);
  localparam logic [CW-1:0] RPT_C     = CW'(RPT_PER);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TO - 1);

  state_t        state_q, state_d;
  logic          mode_q, adv_q;
  logic          mode_rise, adv_rise;
  logic [CW-1:0] idle_q, idle_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [CW-1:0] rpt_q, rpt_d;
  logic          act_q, act_d;
  logic          fire;
  logic          set_state;
  logic [4:0]    strb_sel;
  logic [4:0]    strb_q;

  // A button only counts when it is seen high after having been seen low; the
  // reset value of 1 in the history flops makes buttons held through reset inert.
  assign mode_rise = ModeBtn & ~mode_q;
  assign adv_rise  = AdvBtn & ~adv_q;
  assign set_state = (state_q >= S_MIN) && (state_q <= S_MONTH);

  // state, button history, counters and registered strobes
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_RUN;
      mode_q  <= 1'b1;
      adv_q   <= 1'b1;
      idle_q  <= '0;
      hold_q  <= '0;
      rpt_q   <= '0;
      act_q   <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= ModeBtn;
      adv_q   <= AdvBtn;
      idle_q  <= idle_d;
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
      act_q   <= act_d;
      strb_q  <= fire ? strb_sel : 5'b0;
    end
  end

  // one-hot strobe lane for the current field
  always_comb begin
    strb_sel = 5'b0;
    case (state_q)
      S_MIN:   strb_sel = 5'b00001;
      S_HRS:   strb_sel = 5'b00010;
      S_DAY:   strb_sel = 5'b00100;
      S_DATE:  strb_sel = 5'b01000;
      S_MONTH: strb_sel = 5'b10000;
      default: strb_sel = 5'b0;
    endcase
  end

  // next field, idle timeout and advance/auto-repeat decisions
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    hold_d  = hold_q;
    rpt_d   = rpt_q;
    act_d   = act_q;
    fire    = 1'b0;

    case (state_q)
      S_RUN:   if (mode_rise) state_d = S_MIN;
      S_MIN:   if (mode_rise) state_d = S_HRS;
      S_HRS:   if (mode_rise) state_d = S_DAY;
      S_DAY:   if (mode_rise) state_d = S_DATE;
      S_DATE:  if (mode_rise) state_d = S_MONTH;
      S_MONTH: if (mode_rise) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    if (!set_state || ModeBtn || AdvBtn) begin
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      idle_d  = '0;
      state_d = S_RUN;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    // A field change drops the active press; because a new strobe needs a fresh
    // rise, AdvBtn stays locked out until it has been released.
    if (!set_state || !AdvBtn || (state_d != state_q)) begin
      act_d  = 1'b0;
      hold_d = '0;
      rpt_d  = '0;
    end else if (adv_rise) begin
      fire   = 1'b1;
      act_d  = 1'b1;
      hold_d = {{(CW-1){1'b0}}, 1'b1};
      rpt_d  = '0;
    end else if (act_q) begin
      if (hold_q < HOLD_C) begin
        hold_d = hold_q + 1'b1;
      end else if ((rpt_q == '0) || (rpt_q == RPT_C)) begin
        // rpt_q == 0 marks the first repeat right after the hold delay
        fire  = 1'b1;
        rpt_d = {{(CW-1){1'b0}}, 1'b1};
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  assign Field    = state_q;
  assign Timeset  = (state_q != S_RUN);
  assign Minadv   = strb_q[0];
  assign Hrsadv   = strb_q[1];
  assign Dayadv   = strb_q[2];
  assign DateAdv  = strb_q[3];
  assign MonthAdv = strb_q[4];

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed vectors plus hand-written multi-cycle sequences for
// time_set_ctrl with default parameters (HOLD_DLY=8, RPT_PER=2, IDLE_TO=64).
module tb_time_set_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ModeBtn;
  logic       AdvBtn;
  logic       Timeset;
  logic       Minadv, Hrsadv, Dayadv, DateAdv, MonthAdv;
  logic [2:0] Field;
  logic [4:0] strb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       mode;
    logic       adv;
    logic [2:0] field;
    logic       tset;
    logic [4:0] strb;
  } vec_t;

  vec_t vecs[$];

  time_set_ctrl dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ModeBtn  (ModeBtn),
    .AdvBtn   (AdvBtn),
    .Timeset  (Timeset),
    .Minadv   (Minadv),
    .Hrsadv   (Hrsadv),
    .Dayadv   (Dayadv),
    .DateAdv  (DateAdv),
    .MonthAdv (MonthAdv),
    .Field    (Field)
  );

  always #5 Clk = ~Clk;

  assign strb = {MonthAdv, DateAdv, Dayadv, Hrsadv, Minadv};

  task automatic check(input string name, input logic [2:0] f, input logic t, input logic [4:0] s);
    n_checks++;
    if ({Field, Timeset, strb} !== {f, t, s}) begin
      n_fail++;
      $display("FAIL %s: got field=%0d timeset=%0b strobes=%05b, expected field=%0d timeset=%0b strobes=%05b",
               name, Field, Timeset, strb, f, t, s);
    end
  endtask

  task automatic step(input logic m, input logic a);
    ModeBtn = m;
    AdvBtn  = a;
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic m, input logic a, input logic [2:0] f, input logic [4:0] s);
    vec_t v;
    v.mode  = m;
    v.adv   = a;
    v.field = f;
    v.tset  = (f != 3'd0);
    v.strb  = s;
    vecs.push_back(v);
  endtask

  initial begin
    int strobe_cnt;
    logic [4:0] exp_s;

    Reset   = 1'b1;
    ModeBtn = 1'b0;
    AdvBtn  = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("reset_state", 3'd0, 1'b0, 5'b0);
    Reset = 1'b0;
    step(0, 0);
    check("post_reset_idle", 3'd0, 1'b0, 5'b0);

    // single press into MIN, one Minadv
    add(1, 0, 3'd1, 5'b00000);
    add(0, 0, 3'd1, 5'b00000);
    add(0, 1, 3'd1, 5'b00001);
    add(0, 0, 3'd1, 5'b00000);
    add(0, 0, 3'd1, 5'b00000);
    // walk the rest of the ring back to RUN
    add(1, 0, 3'd2, 5'b00000);
    add(0, 0, 3'd2, 5'b00000);
    add(1, 0, 3'd3, 5'b00000);
    add(0, 0, 3'd3, 5'b00000);
    add(1, 0, 3'd4, 5'b00000);
    add(0, 0, 3'd4, 5'b00000);
    add(1, 0, 3'd5, 5'b00000);
    add(0, 0, 3'd5, 5'b00000);
    add(1, 0, 3'd0, 5'b00000);
    add(0, 0, 3'd0, 5'b00000);
    // AdvBtn ignored in RUN
    add(0, 1, 3'd0, 5'b00000);
    add(0, 0, 3'd0, 5'b00000);
    // one strobe on each remaining lane
    add(1, 0, 3'd1, 5'b00000);
    add(1, 0, 3'd1, 5'b00000);
    add(0, 0, 3'd1, 5'b00000);
    add(1, 0, 3'd2, 5'b00000);
    add(0, 1, 3'd2, 5'b00010);
    add(0, 0, 3'd2, 5'b00000);
    add(1, 0, 3'd3, 5'b00000);
    add(0, 1, 3'd3, 5'b00100);
    add(0, 0, 3'd3, 5'b00000);
    add(1, 0, 3'd4, 5'b00000);
    add(0, 1, 3'd4, 5'b01000);
    add(0, 0, 3'd4, 5'b00000);
    add(1, 0, 3'd5, 5'b00000);
    add(0, 1, 3'd5, 5'b10000);
    add(0, 0, 3'd5, 5'b00000);
    add(1, 0, 3'd0, 5'b00000);
    add(0, 0, 3'd0, 5'b00000);

    foreach (vecs[i]) begin
      step(vecs[i].mode, vecs[i].adv);
      check($sformatf("vec%0d", i), vecs[i].field, vecs[i].tset, vecs[i].strb);
    end

    // go to DATE, then hold AdvBtn for 20 edges
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      step(0, 0);
    end
    check("date_reached", 3'd4, 1'b1, 5'b0);
    strobe_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step(0, 1);
      exp_s = (j == 0 || (j >= 8 && j % 2 == 0)) ? 5'b01000 : 5'b00000;
      if (DateAdv) strobe_cnt++;
      check($sformatf("repeat_j%0d", j), 3'd4, 1'b1, exp_s);
    end
    for (int j = 0; j < 5; j++) begin
      step(0, 0);
      if (DateAdv) strobe_cnt++;
      check($sformatf("released_%0d", j), 3'd4, 1'b1, 5'b0);
    end
    n_checks++;
    if (strobe_cnt != 7) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d strobes, expected 7", strobe_cnt);
    end

    // DATE -> MONTH -> RUN -> MIN -> HRS, then idle timeout
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      step(0, 0);
    end
    step(1, 0);
    check("hrs_reached", 3'd2, 1'b1, 5'b0);
    for (int j = 1; j <= 63; j++) begin
      step(0, 0);
      check($sformatf("idle_%0d", j), 3'd2, 1'b1, 5'b0);
    end
    step(0, 0);
    check("idle_timeout", 3'd0, 1'b0, 5'b0);

    // Mode and Adv rise together in MIN: Mode wins, Adv locked out while held
    step(1, 0);
    step(0, 0);
    check("min_for_tie", 3'd1, 1'b1, 5'b0);
    step(1, 1);
    check("tie_edge", 3'd2, 1'b1, 5'b0);
    for (int j = 0; j < 19; j++) begin
      step(0, 1);
      check($sformatf("lockout_%0d", j), 3'd2, 1'b1, 5'b0);
    end
    step(0, 0);
    check("lockout_release", 3'd2, 1'b1, 5'b0);
    step(0, 1);
    check("repress_hrs", 3'd2, 1'b1, 5'b00010);
    step(0, 0);
    check("repress_hrs_end", 3'd2, 1'b1, 5'b0);

    // HRS -> DAY -> DATE, repeat in progress, then reset with both buttons held
    step(1, 0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    check("date_again", 3'd4, 1'b1, 5'b0);
    for (int j = 0; j <= 10; j++) step(0, 1);
    check("strobe_before_reset", 3'd4, 1'b1, 5'b01000);
    Reset   = 1'b1;
    ModeBtn = 1'b1;
    #1;
    check("async_reset", 3'd0, 1'b0, 5'b0);
    @(posedge Clk);
    #1;
    check("in_reset", 3'd0, 1'b0, 5'b0);
    Reset = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step(1, 1);
      check($sformatf("held_after_reset_%0d", j), 3'd0, 1'b0, 5'b0);
    end
    step(0, 1);
    check("mode_released", 3'd0, 1'b0, 5'b0);
    step(1, 1);
    check("mode_repressed", 3'd1, 1'b1, 5'b0);
    step(0, 1);
    check("adv_still_held", 3'd1, 1'b1, 5'b0);
    step(0, 0);
    check("adv_released", 3'd1, 1'b1, 5'b0);
    step(0, 1);
    check("adv_repressed", 3'd1, 1'b1, 5'b00001);
    step(0, 0);
    check("final", 3'd1, 1'b1, 5'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
